spi_loader: RTL and testbench
=============================

# spi_loader

Loads bubble-memory image data from an external W25Q32-class SPI NOR flash into the on-chip bit buffer. On a load request from the access controller it issues a single flash Read Data (0x03) transaction. It streams the returned bits one at a time into the buffer write port. The block sits between the bubble timing/access controller (IMGNUM, ACCTYPE, ABSPOS) and the page buffer RAM.

## Interface
No parameters; all sizes are fixed constants from the shared package.
- MCLK  in  1  master clock, 50 MHz nominal; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- IMGNUM  in  3  image slot select (8 images of 512 KiB each)
- ACCTYPE  in  3  access request: 3'b000 idle, 3'b110 bootloop load, 3'b111 page load, other codes no flash access
- ABSPOS  in  12  absolute page number for page load (0..4095)
- BUFWADDR  out  15  buffer bit address
- BUFWDATA  out  1  buffer bit data
- BUFWCLK  out  1  buffer write strobe, one MCLK cycle high per bit
- nCS  out  1  flash chip select, active low
- MOSI  out  1  flash serial data in
- MISO  in  1  flash serial data out
- CLK  out  1  flash serial clock, SPI mode 0
- nWP  out  1  constant 1
- nHOLD  out  1  constant 1; also drives flash RESETn

## Operation
- Flash byte address (24 bit), MSB first:
  - Bootloop: IMGNUM<<19.
  - Page: (IMGNUM<<19) + 0x400 + ABSPOS*64.
- Transfer length: bootloop 8192 bits (1 KiB), buffer addresses 0..8191. Page 512 bits (64 B), buffer addresses 0..511.
- ACCTYPE is registered each MCLK. A transfer starts when the registered code becomes 110 or 111 and differs from the previous registered value.
- FSM states:
  - IDLE: on start, go to CMD.
  - CMD: 8 bits of 0x03. Then ADDR.
  - ADDR: 24 bits. Then DATA.
  - DATA: N bits. Then DONE.
  - DONE: nCS high. Stay in DONE while ACCTYPE is unchanged; return to IDLE when ACCTYPE changes.
- Abort: if ACCTYPE changes away from the active code during CMD, ADDR or DATA, raise nCS immediately and go to IDLE. No further buffer writes occur; already-written bits remain.
- A new start is accepted only from IDLE after at least 4 MCLK cycles with nCS high.
- Data bits are written MSB-first per byte. BUFWADDR increments by 1 per bit, starting at 0.

## Timing
- Reset values: nCS=1, CLK=0, MOSI=0, BUFWADDR=0, BUFWDATA=0, BUFWCLK=0, nWP=1, nHOLD=1. FSM goes to IDLE.
- CLK = MCLK/2 while nCS is low: one MCLK cycle low, one cycle high. CLK idles low.
- nCS falls at least 1 MCLK before the first CLK rise. nCS rises at least 1 MCLK after the last CLK fall.
- MOSI changes only in the MCLK cycle in which CLK goes low (or at nCS fall for the first bit). The flash samples MOSI on the CLK rise.
- MISO is sampled on the MCLK edge that drives CLK high. This is one full MCLK period after the flash shifts on the CLK fall.
- Each sampled data bit:
  - BUFWDATA and BUFWADDR update on the next MCLK edge.
  - BUFWCLK goes high on the following edge, for 1 cycle.
  - Address and data are stable around the BUFWCLK rise.
- Total latency, start to last BUFWCLK:
  - Bootloop: about 2*(32+8192)+4 = 16452 MCLK (about 329 µs at 50 MHz).
  - Page: about 1092 MCLK.
- RST asserted mid-transfer: nCS=1 on the next edge, all outputs return to reset values.

## Structure
- Shared package spi_loader_pkg holds:
  - ACCTYPE codes (IDLE=3'b000, BOOT=3'b110, PAGE=3'b111)
  - READ_CMD=8'h03
  - BOOT_BITS=8192, PAGE_BITS=512, PAGE_BYTES=64
  - PAGE_BASE=24'h000400, IMAGE_SHIFT=19
- One natural sub-module, spi_bit_engine. It handles the CLK divide, the shift-out of the 32-bit header, bit sampling, and the bit counter. The top level holds the request detect, address computation, FSM and buffer write port.

## Test plan
- Reset, then ACCTYPE=000 for 10 µs → nCS stays 1, CLK stays 0, no BUFWCLK pulses.
- IMGNUM=0, ACCTYPE 000→110 → MOSI header is 0x03 followed by 0x000000. Exactly 8192 BUFWCLK pulses, BUFWADDR 0..8191. BUFWDATA matches flash bytes 0x000000..0x0003FF MSB-first. Finishes within 600 µs, then nCS=1.
- ACCTYPE 000→001→111 with ABSPOS=1018, IMGNUM=0 → address sent is 0x010280. 512 pulses, BUFWADDR 0..511. Data matches flash bytes 0x010280..0x0102BF. Completes in about 22 µs.
- IMGNUM=5, page load, ABSPOS=0 → address sent is 0x280400.
- ACCTYPE 110→000 mid-DATA → nCS rises within 1 MCLK, no further BUFWCLK. A following 111 request runs a full page load.
- RST pulse mid-transfer → all outputs at reset values on the next edge, FSM in IDLE.

Source files
------------

// File: rtl/spi_loader_pkg.sv
// Shared request codes, transfer sizes and flash address helper for the bubble image loader.
package spi_loader_pkg;

    localparam logic [2:0] ACC_IDLE = 3'b000;
    localparam logic [2:0] ACC_BOOT = 3'b110;
    localparam logic [2:0] ACC_PAGE = 3'b111;

    localparam logic [7:0] READ_CMD = 8'h03;

    localparam int                CNT_W     = 14;
    localparam logic [CNT_W-1:0]  CMD_BITS  = 14'd8;
    localparam logic [CNT_W-1:0]  HDR_BITS  = 14'd32;
    localparam logic [CNT_W-1:0]  BOOT_BITS = 14'd8192;
    localparam logic [CNT_W-1:0]  PAGE_BITS = 14'd512;

    localparam logic [23:0] PAGE_BYTES  = 24'd64;
    localparam logic [23:0] PAGE_BASE   = 24'h000400;
    localparam int          IMAGE_SHIFT = 19;

    // Minimum nCS-high gap before a new transaction may begin.
    localparam logic [2:0]  COOL_CYCLES = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    function automatic logic is_load_code(input logic [2:0] code);
        return (code == ACC_BOOT) || (code == ACC_PAGE);
    endfunction

    function automatic logic [23:0] flash_addr(input logic [2:0]  img,
                                               input logic        page,
                                               input logic [11:0] abspos);
        logic [23:0] a;
        a = {21'd0, img} << IMAGE_SHIFT;
        if (page) begin
            a = a + PAGE_BASE + ({12'd0, abspos} * PAGE_BYTES);
        end
        return a;
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 shifter: MCLK/2 serial clock, 32-bit header out, then samples N data bits on each CLK rise.
// nCS rises one MCLK after the last CLK fall; abort drops nCS on the next edge.
module spi_bit_engine
    import spi_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [31:0]       hdr_i,
    input  logic [CNT_W-1:0]  nbits_i,
    input  logic              miso_i,
    output logic              ncs_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              bit_vld_o,
    output logic              bit_dat_o,
    output logic              done_o
);

    logic              active_q;
    logic              tail_q;
    logic              ncs_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              bit_vld_q;
    logic              bit_dat_q;
    logic [30:0]       sr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  total_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            tail_q    <= 1'b0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            bit_vld_q <= 1'b0;
            bit_dat_q <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            total_q   <= '0;
        end else begin
            bit_vld_q <= 1'b0;
            if (abort_i) begin
                active_q <= 1'b0;
                tail_q   <= 1'b0;
                ncs_q    <= 1'b1;
                sclk_q   <= 1'b0;
                mosi_q   <= 1'b0;
            end else if (start_i) begin
                // First header bit is presented together with the nCS fall.
                active_q <= 1'b1;
                tail_q   <= 1'b0;
                ncs_q    <= 1'b0;
                sclk_q   <= 1'b0;
                mosi_q   <= hdr_i[31];
                sr_q     <= hdr_i[30:0];
                cnt_q    <= '0;
                total_q  <= HDR_BITS + nbits_i;
            end else if (tail_q) begin
                active_q <= 1'b0;
                tail_q   <= 1'b0;
                ncs_q    <= 1'b1;
            end else if (active_q && !sclk_q) begin
                sclk_q <= 1'b1;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q >= HDR_BITS) begin
                    bit_vld_q <= 1'b1;
                    bit_dat_q <= miso_i;
                end
            end else if (active_q) begin
                sclk_q <= 1'b0;
                if (cnt_q == total_q) begin
                    tail_q <= 1'b1;
                end
                // Past the header the flash ignores MOSI; park it low.
                if (cnt_q < HDR_BITS) begin
                    mosi_q <= sr_q[30];
                    sr_q   <= {sr_q[29:0], 1'b0};
                end else begin
                    mosi_q <= 1'b0;
                end
            end
        end
    end

    assign ncs_o     = ncs_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cnt_o     = cnt_q;
    assign bit_vld_o = bit_vld_q;
    assign bit_dat_o = bit_dat_q;
    assign done_o    = tail_q;

endmodule

// File: rtl/spi_loader.sv
// Loads one bootloop (8192 bits) or page (512 bits) image slice from SPI NOR into the bit buffer.
// Request on ACCTYPE edge to 110/111; ACCTYPE change mid-transfer aborts with nCS high on the next edge.
module spi_loader
    import spi_loader_pkg::*;
(
    input  logic         MCLK,
    input  logic         RST,
    input  logic [2:0]   IMGNUM,
    input  logic [2:0]   ACCTYPE,
    input  logic [11:0]  ABSPOS,
    output logic [14:0]  BUFWADDR,
    output logic         BUFWDATA,
    output logic         BUFWCLK,
    output logic         nCS,
    output logic         MOSI,
    input  logic         MISO,
    output logic         CLK,
    output logic         nWP,
    output logic         nHOLD
);

    logic [2:0]        acc_q;
    logic [2:0]        acc_prev_q;
    logic [2:0]        act_code_q;
    logic              pend_q;
    logic [2:0]        cool_q;
    state_t            state_q;
    logic [14:0]       wcnt_q;
    logic [14:0]       bufwaddr_q;
    logic              bufwdata_q;
    logic              bufwclk_q;
    logic              wpend_q;

    logic              eng_ncs;
    logic              eng_sclk;
    logic              eng_mosi;
    logic              eng_bit_vld;
    logic              eng_bit_dat;
    logic              eng_done;
    logic [CNT_W-1:0]  eng_cnt;

    logic              edge_d;
    logic              xfer_d;
    logic              abort_d;
    logic              start_d;
    logic              page_d;
    logic [31:0]       hdr_d;
    logic [CNT_W-1:0]  nbits_d;

    always_comb begin
        edge_d  = is_load_code(acc_q) && (acc_q != acc_prev_q);
        xfer_d  = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
        // Raw ACCTYPE so nCS rises on the very next edge after the request is withdrawn.
        abort_d = xfer_d && (ACCTYPE != act_code_q);
        start_d = (state_q == ST_IDLE) && is_load_code(acc_q) && (pend_q || edge_d)
                  && (cool_q == COOL_CYCLES);
        page_d  = (acc_q == ACC_PAGE);
        hdr_d   = {READ_CMD, flash_addr(IMGNUM, page_d, ABSPOS)};
        nbits_d = page_d ? PAGE_BITS : BOOT_BITS;
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            acc_q      <= ACC_IDLE;
            acc_prev_q <= ACC_IDLE;
            act_code_q <= ACC_IDLE;
            pend_q     <= 1'b0;
            cool_q     <= '0;
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            bufwaddr_q <= '0;
            bufwdata_q <= 1'b0;
            bufwclk_q  <= 1'b0;
            wpend_q    <= 1'b0;
        end else begin
            acc_q      <= ACCTYPE;
            acc_prev_q <= acc_q;

            // A request seen while still cooling down is held until it can be served.
            if (start_d) begin
                pend_q <= 1'b0;
            end else if (edge_d) begin
                pend_q <= 1'b1;
            end else if (!is_load_code(acc_q)) begin
                pend_q <= 1'b0;
            end

            if (!eng_ncs) begin
                cool_q <= '0;
            end else if (cool_q != COOL_CYCLES) begin
                cool_q <= cool_q + 3'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q    <= ST_CMD;
                        act_code_q <= acc_q;
                        wcnt_q     <= '0;
                    end
                end
                ST_CMD: begin
                    if (abort_d) begin
                        state_q <= ST_IDLE;
                    end else if (eng_cnt >= CMD_BITS) begin
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (abort_d) begin
                        state_q <= ST_IDLE;
                    end else if (eng_cnt >= HDR_BITS) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (abort_d) begin
                        state_q <= ST_IDLE;
                    end else if (eng_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (acc_q != act_code_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Address/data land one edge ahead of the strobe so they are settled at its rise.
            wpend_q   <= eng_bit_vld && !abort_d;
            bufwclk_q <= wpend_q && !abort_d;
            if (eng_bit_vld && !abort_d) begin
                bufwaddr_q <= wcnt_q;
                bufwdata_q <= eng_bit_dat;
                wcnt_q     <= wcnt_q + 15'd1;
            end
        end
    end

    spi_bit_engine u_engine (
        .clk_i     (MCLK),
        .rst_i     (RST),
        .start_i   (start_d),
        .abort_i   (abort_d),
        .hdr_i     (hdr_d),
        .nbits_i   (nbits_d),
        .miso_i    (MISO),
        .ncs_o     (eng_ncs),
        .sclk_o    (eng_sclk),
        .mosi_o    (eng_mosi),
        .cnt_o     (eng_cnt),
        .bit_vld_o (eng_bit_vld),
        .bit_dat_o (eng_bit_dat),
        .done_o    (eng_done)
    );

    assign nCS      = eng_ncs;
    assign CLK      = eng_sclk;
    assign MOSI     = eng_mosi;
    assign BUFWADDR = bufwaddr_q;
    assign BUFWDATA = bufwdata_q;
    assign BUFWCLK  = bufwclk_q;
    assign nWP      = 1'b1;
    assign nHOLD    = 1'b1;

endmodule

// File: tb/tb_spi_loader.sv
// Bench for spi_loader: behavioural NOR flash with seeded contents, buffer-write capture and SPI protocol watch.
module tb_spi_loader;

    logic        MCLK    = 1'b0;
    logic        RST     = 1'b1;
    logic [2:0]  IMGNUM  = 3'd0;
    logic [2:0]  ACCTYPE = 3'b000;
    logic [11:0] ABSPOS  = 12'd0;
    logic        MISO    = 1'b0;
    logic [14:0] BUFWADDR;
    logic        BUFWDATA;
    logic        BUFWCLK;
    logic        nCS;
    logic        MOSI;
    logic        CLK;
    logic        nWP;
    logic        nHOLD;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int seed   = 0;
    int req_cyc     = 0;
    int last_wr_cyc = 0;
    int wr_addr[$];
    bit wr_dat[$];

    logic [31:0] fl_hdr = 32'd0;
    int          fl_cnt = 0;
    int          fl_k   = 0;
    logic [7:0]  fl_b   = 8'd0;
    int          clk_rises = 0;
    int          proto_err = 0;
    logic        prev_clk  = 1'b0;
    logic        prev_ncs  = 1'b1;
    logic        prev_mosi = 1'b0;

    spi_loader dut (
        .MCLK     (MCLK),
        .RST      (RST),
        .IMGNUM   (IMGNUM),
        .ACCTYPE  (ACCTYPE),
        .ABSPOS   (ABSPOS),
        .BUFWADDR (BUFWADDR),
        .BUFWDATA (BUFWDATA),
        .BUFWCLK  (BUFWCLK),
        .nCS      (nCS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .CLK      (CLK),
        .nWP      (nWP),
        .nHOLD    (nHOLD)
    );

    always #10 MCLK = ~MCLK;
    always @(posedge MCLK) cyc++;

    function automatic logic [7:0] fbyte(input int a);
        int v;
        v = a * 37 + (a >> 8) * 11 + (a >> 16) * 101 + seed;
        return v[7:0];
    endfunction

    function automatic int exp_base(input bit page, input int img, input int pos);
        return img * 524288 + (page ? 1024 + pos * 64 : 0);
    endfunction

    function automatic bit exp_bit(input int base, input int i);
        logic [7:0] b;
        b = fbyte(base + i / 8);
        return b[7 - (i % 8)];
    endfunction

    // Flash: header shifted in on CLK rise, data shifted out on CLK fall.
    always @(negedge nCS) fl_cnt = 0;
    always @(posedge CLK) begin
        clk_rises++;
        if (nCS === 1'b0) begin
            if (fl_cnt < 32) fl_hdr = {fl_hdr[30:0], MOSI};
            fl_cnt++;
        end
    end
    always @(negedge CLK) begin
        if (nCS === 1'b0 && fl_cnt >= 32) begin
            fl_k = fl_cnt - 32;
            fl_b = fbyte(int'(fl_hdr[23:0]) + fl_k / 8);
            MISO = fl_b[7 - (fl_k % 8)];
        end
    end

    always @(negedge MCLK) begin
        if (BUFWCLK === 1'b1) begin
            wr_addr.push_back(int'(BUFWADDR));
            wr_dat.push_back(BUFWDATA);
            last_wr_cyc = cyc;
        end
        if (!RST) begin
            if ((MOSI !== prev_mosi) && !(prev_clk === 1'b1 && CLK === 1'b0)
                && (nCS === prev_ncs) && (nCS !== 1'b1)) proto_err++;
            if (CLK === 1'b1 && nCS === 1'b1) proto_err++;
            if (CLK === 1'b1 && prev_clk === 1'b0 && prev_ncs !== 1'b0) proto_err++;
        end
        prev_mosi = MOSI;
        prev_clk  = CLK;
        prev_ncs  = nCS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic count_errs(input int base, output int aerr, output int derr);
        aerr = 0;
        derr = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != i) aerr++;
            if (wr_dat[i] != exp_bit(base, i)) derr++;
        end
    endtask

    task automatic request(input logic [2:0] code, input logic [2:0] img, input logic [11:0] pos);
        @(negedge MCLK);
        wr_addr.delete();
        wr_dat.delete();
        IMGNUM  = img;
        ABSPOS  = pos;
        ACCTYPE = code;
        req_cyc = cyc;
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int t;
        t = 0;
        while (wr_addr.size() < n && t < limit) begin
            @(negedge MCLK);
            t++;
        end
        chk({tag, ".in_time"}, 32'(wr_addr.size() >= n), 32'd1);
    endtask

    task automatic check_xfer(input string tag, input int base, input int n);
        int t;
        int aerr;
        int derr;
        t = 0;
        while (nCS !== 1'b1 && t < 20) begin
            @(negedge MCLK);
            t++;
        end
        chk({tag, ".ncs_end"}, 32'(nCS), 32'd1);
        chk({tag, ".hdr"}, fl_hdr, 32'h0300_0000 | base);
        chk({tag, ".count"}, wr_addr.size(), n);
        count_errs(base, aerr, derr);
        chk({tag, ".addr_err"}, aerr, 0);
        chk({tag, ".data_err"}, derr, 0);
        chk({tag, ".latency"}, 32'((last_wr_cyc - req_cyc) >= 2 * (32 + n)
                                  && (last_wr_cyc - req_cyc) <= 2 * (32 + n) + 8), 32'd1);
    endtask

    task automatic idle_gap();
        @(negedge MCLK);
        ACCTYPE = 3'b000;
        repeat (10) @(negedge MCLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".nCS"},      32'(nCS),      32'd1);
        chk({tag, ".CLK"},      32'(CLK),      32'd0);
        chk({tag, ".MOSI"},     32'(MOSI),     32'd0);
        chk({tag, ".BUFWADDR"}, 32'(BUFWADDR), 32'd0);
        chk({tag, ".BUFWDATA"}, 32'(BUFWDATA), 32'd0);
        chk({tag, ".BUFWCLK"},  32'(BUFWCLK),  32'd0);
        chk({tag, ".nWP"},      32'(nWP),      32'd1);
        chk({tag, ".nHOLD"},    32'(nHOLD),    32'd1);
    endtask

    initial begin
        int base;
        int n0;
        int r0;
        int aerr;
        int derr;
        logic [2:0]  img;
        logic [11:0] pos;

        seed = int'($urandom_range(0, 255));

        repeat (3) @(negedge MCLK);
        check_reset_outputs("reset");
        RST = 1'b0;

        // 10 us of idle requests: bus must stay quiet.
        r0 = clk_rises;
        repeat (500) @(negedge MCLK);
        chk("idle.writes", wr_addr.size(), 0);
        chk("idle.clk_rises", clk_rises - r0, 0);
        chk("idle.nCS", 32'(nCS), 32'd1);

        request(3'b110, 3'd0, 12'd0);
        wait_writes("boot", 8192, 30000);
        check_xfer("boot", exp_base(1'b0, 0, 0), 8192);
        idle_gap();

        @(negedge MCLK);
        ACCTYPE = 3'b001;
        repeat (3) @(negedge MCLK);
        request(3'b111, 3'd0, 12'd1018);
        wait_writes("page1018", 512, 2000);
        check_xfer("page1018", exp_base(1'b1, 0, 1018), 512);
        idle_gap();

        request(3'b111, 3'd5, 12'd0);
        wait_writes("img5", 512, 2000);
        check_xfer("img5", exp_base(1'b1, 5, 0), 512);
        idle_gap();

        request(3'b111, 3'd7, 12'd4095);
        wait_writes("top_page", 512, 2000);
        check_xfer("top_page", exp_base(1'b1, 7, 4095), 512);
        idle_gap();

        for (int it = 0; it < 3; it++) begin
            img = 3'($urandom_range(0, 7));
            pos = 12'($urandom_range(0, 4095));
            request(3'b111, img, pos);
            wait_writes("rnd_page", 512, 2000);
            check_xfer("rnd_page", exp_base(1'b1, int'(img), int'(pos)), 512);
            idle_gap();
        end

        // Withdraw a bootloop request in the middle of its data phase.
        img  = 3'($urandom_range(0, 7));
        base = exp_base(1'b0, int'(img), 0);
        request(3'b110, img, 12'd0);
        wait_writes("abort", 200, 2000);
        @(negedge MCLK);
        #1;
        n0 = wr_addr.size();
        ACCTYPE = 3'b000;
        @(negedge MCLK);
        chk("abort.nCS", 32'(nCS), 32'd1);
        chk("abort.CLK", 32'(CLK), 32'd0);
        repeat (100) @(negedge MCLK);
        chk("abort.no_more_writes", wr_addr.size(), n0);
        chk("abort.hdr", fl_hdr, 32'h0300_0000 | base);
        count_errs(base, aerr, derr);
        chk("abort.prefix_addr_err", aerr, 0);
        chk("abort.prefix_data_err", derr, 0);

        img = 3'($urandom_range(0, 7));
        pos = 12'($urandom_range(0, 4095));
        request(3'b111, img, pos);
        wait_writes("after_abort", 512, 2000);
        check_xfer("after_abort", exp_base(1'b1, int'(img), int'(pos)), 512);
        idle_gap();

        // Reset pulse in the middle of a page load.
        request(3'b111, 3'd2, 12'd100);
        wait_writes("rst_mid", 50, 2000);
        @(negedge MCLK);
        RST     = 1'b1;
        ACCTYPE = 3'b000;
        @(negedge MCLK);
        check_reset_outputs("rst_mid");
        RST = 1'b0;
        n0 = wr_addr.size();
        repeat (20) @(negedge MCLK);
        chk("rst_mid.quiet_nCS", 32'(nCS), 32'd1);
        chk("rst_mid.no_more_writes", wr_addr.size(), n0);

        img = 3'($urandom_range(0, 7));
        pos = 12'($urandom_range(0, 4095));
        request(3'b111, img, pos);
        wait_writes("after_rst", 512, 2000);
        check_xfer("after_rst", exp_base(1'b1, int'(img), int'(pos)), 512);
        idle_gap();

        chk("protocol_err", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
